mbist_fault_mem: RTL and testbench

- Responder end of the MBIST memory interface: a synchronous RAM the MBIST controller reads and writes through `read`/`write`/`address`/`din`/`dout`.
- Programmable fault injection (stuck-at, transition, coupling) lets the controller's march algorithms be exercised against known defects without simulator `force`.
- Clears itself after reset and counts fault-affected accesses for bench cross-checking.
- Sits between `mbist_subsystem`'s memory-side outputs and the bench, replacing `test_mem` when fault coverage is under test.

---
 rtl/mbist_pkg.sv | 28 ++
 rtl/mbist_fault_slot.sv | 84 ++++++++
 rtl/mbist_fault_mem.sv | 141 ++++++++++++++
 tb/tb_mbist_fault_mem.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared fault types, FSM states and slot record for mbist_fault_mem
package mbist_pkg;

    localparam logic [2:0] FT_SA0    = 3'd0;
    localparam logic [2:0] FT_SA1    = 3'd1;
    localparam logic [2:0] FT_TF_UP  = 3'd2;
    localparam logic [2:0] FT_TF_DN  = 3'd3;
    localparam logic [2:0] FT_CF_INV = 3'd4;

    // Slot fields are sized for the largest supported memory; narrower ports zero-extend.
    localparam int SLOT_AW = 16;
    localparam int SLOT_BW = 5;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic               en;
        logic [2:0]         ftype;
        logic [SLOT_AW-1:0] vaddr;
        logic [SLOT_BW-1:0] vbit;
        logic [SLOT_AW-1:0] aaddr;
        logic [SLOT_BW-1:0] abit;
    } slot_t;

endpackage

// File: rtl/mbist_fault_slot.sv
// rtl/mbist_fault_slot.sv - one fault slot: config registers and per-bit claim/value/invert masks
module mbist_fault_slot
    import mbist_pkg::*;
#(
    parameter int addr = 3,
    parameter int data = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_wr,
    input  logic                    cfg_en,
    input  logic [2:0]              cfg_type,
    input  logic [addr-1:0]         cfg_vaddr,
    input  logic [$clog2(data)-1:0] cfg_vbit,
    input  logic [addr-1:0]         cfg_aaddr,
    input  logic [$clog2(data)-1:0] cfg_abit,
    input  logic                    wr_en,
    input  logic [addr-1:0]         address,
    input  logic [data-1:0]         old_word,
    input  logic [data-1:0]         new_word,
    input  logic [data-1:0]         stored_word,
    output logic [data-1:0]         claim_wr,
    output logic [data-1:0]         claim_rd,
    output logic [data-1:0]         val,
    output logic [data-1:0]         inv_mask,
    output logic [addr-1:0]         inv_addr
);

    slot_t slot_q;
    logic [data-1:0] vmask, amask;
    logic vhit, ahit, fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else if (cfg_wr) begin
            slot_q.en    <= cfg_en && (cfg_type <= FT_CF_INV);
            slot_q.ftype <= cfg_type;
            slot_q.vaddr <= SLOT_AW'(cfg_vaddr);
            slot_q.vbit  <= SLOT_BW'(cfg_vbit);
            slot_q.aaddr <= SLOT_AW'(cfg_aaddr);
            slot_q.abit  <= SLOT_BW'(cfg_abit);
        end
    end

    assign vmask = data'(1) << slot_q.vbit;
    assign amask = data'(1) << slot_q.abit;
    assign vhit  = slot_q.en && (slot_q.vaddr == SLOT_AW'(address));
    assign ahit  = slot_q.en && (slot_q.ftype == FT_CF_INV) && (slot_q.aaddr == SLOT_AW'(address));

    // val carries the bit this slot wants stored/returned, meaningful only under its claim.
    always_comb begin
        claim_wr = '0;
        claim_rd = '0;
        val      = '0;
        if (vhit) begin
            case (slot_q.ftype)
                FT_SA0: begin
                    claim_wr = vmask;
                    claim_rd = vmask;
                end
                FT_SA1: begin
                    claim_wr = vmask;
                    claim_rd = vmask;
                    val      = vmask;
                end
                FT_TF_UP: begin
                    claim_wr = vmask;
                    val      = ((~old_word & new_word & vmask) != '0) ? '0 : (new_word & vmask);
                end
                FT_TF_DN: begin
                    claim_wr = vmask;
                    val      = ((old_word & ~new_word & vmask) != '0) ? vmask : (new_word & vmask);
                end
                default: ;
            endcase
        end
    end

    assign fire     = wr_en && ahit && (((old_word ^ stored_word) & amask) != '0);
    assign inv_mask = fire ? vmask : '0;
    assign inv_addr = slot_q.vaddr[addr-1:0];

endmodule

// File: rtl/mbist_fault_mem.sv
// rtl/mbist_fault_mem.sv - MBIST-facing RAM with self-clear and programmable fault injection
module mbist_fault_mem
    import mbist_pkg::*;
#(
    parameter int addr   = 3,
    parameter int data   = 8,
    parameter int NFAULT = 4,
    parameter int CNTW   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read,
    input  logic                      write,
    input  logic [addr-1:0]           address,
    input  logic [data-1:0]           din,
    output logic [data-1:0]           dout,
    output logic                      busy,
    input  logic                      cfg_wr,
    input  logic [$clog2(NFAULT)-1:0] cfg_idx,
    input  logic                      cfg_en,
    input  logic [2:0]                cfg_type,
    input  logic [addr-1:0]           cfg_vaddr,
    input  logic [$clog2(data)-1:0]   cfg_vbit,
    input  logic [addr-1:0]           cfg_aaddr,
    input  logic [$clog2(data)-1:0]   cfg_abit,
    output logic [CNTW-1:0]           hit_cnt
);

    localparam int DEPTH = 2 ** addr;
    localparam int IW    = $clog2(NFAULT);

    state_t          state, state_nxt;
    logic [addr-1:0] clr_cnt;
    logic [data-1:0] mem [DEPTH];
    logic [data-1:0] inv [DEPTH];
    logic [data-1:0] claim_wr [NFAULT];
    logic [data-1:0] claim_rd [NFAULT];
    logic [data-1:0] val      [NFAULT];
    logic [data-1:0] inv_mask [NFAULT];
    logic [addr-1:0] inv_addr [NFAULT];
    logic [data-1:0] old_word, wr_word, rd_word, final_word, taken_w, taken_r;
    logic            acc_rd, acc_wr, other_inv, hit;

    assign acc_wr   = !busy && write;
    assign acc_rd   = !busy && read && !write;
    assign old_word = mem[address];

    for (genvar i = 0; i < NFAULT; i++) begin : g_slot
        mbist_fault_slot #(.addr(addr), .data(data)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .cfg_wr     (cfg_wr && (cfg_idx == IW'(i))),
            .cfg_en     (cfg_en),
            .cfg_type   (cfg_type),
            .cfg_vaddr  (cfg_vaddr),
            .cfg_vbit   (cfg_vbit),
            .cfg_aaddr  (cfg_aaddr),
            .cfg_abit   (cfg_abit),
            .wr_en      (acc_wr),
            .address    (address),
            .old_word   (old_word),
            .new_word   (din),
            .stored_word(wr_word),
            .claim_wr   (claim_wr[i]),
            .claim_rd   (claim_rd[i]),
            .val        (val[i]),
            .inv_mask   (inv_mask[i]),
            .inv_addr   (inv_addr[i])
        );
    end

    // Lower slot index claims a bit first; later slots only touch unclaimed bits.
    always_comb begin
        wr_word = din;
        rd_word = old_word;
        taken_w = '0;
        taken_r = '0;
        for (int i = 0; i < NFAULT; i++) begin
            wr_word = (wr_word & ~(claim_wr[i] & ~taken_w)) | (val[i] & claim_wr[i] & ~taken_w);
            rd_word = (rd_word & ~(claim_rd[i] & ~taken_r)) | (val[i] & claim_rd[i] & ~taken_r);
            taken_w = taken_w | claim_wr[i];
            taken_r = taken_r | claim_rd[i];
        end
    end

    always_comb begin
        other_inv = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            inv[a] = '0;
            for (int i = 0; i < NFAULT; i++) begin
                if (inv_addr[i] == addr'(a)) inv[a] = inv[a] | inv_mask[i];
            end
            if ((addr'(a) != address) && (inv[a] != '0)) other_inv = 1'b1;
        end
        final_word = wr_word ^ inv[address];
    end

    always_comb begin
        hit = 1'b0;
        if (acc_wr)      hit = (final_word != din) || other_inv;
        else if (acc_rd) hit = (rd_word != old_word);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && clr_cnt == addr'(DEPTH - 1)) state_nxt = ST_READY;
    end

    always_comb begin
        busy = (state == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
            dout    <= '0;
            hit_cnt <= '0;
        end else begin
            if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
            if (acc_rd) dout <= rd_word;
            if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < DEPTH; a++) begin
            if (state == ST_INIT) begin
                if (clr_cnt == addr'(a)) mem[a] <= '0;
            end else if (acc_wr) begin
                if (address == addr'(a)) mem[a] <= final_word;
                else                     mem[a] <= mem[a] ^ inv[a];
            end
        end
    end

endmodule

// File: tb/tb_mbist_fault_mem.sv
// tb/tb_mbist_fault_mem.sv - directed self-checking bench for mbist_fault_mem
module tb_mbist_fault_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0, write = 1'b0;
    logic [2:0] address = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       busy;
    logic       cfg_wr = 1'b0, cfg_en = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [2:0] cfg_type = '0, cfg_vaddr = '0, cfg_vbit = '0, cfg_aaddr = '0, cfg_abit = '0;
    logic [7:0] hit_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    mbist_fault_mem #(.addr(3), .data(8), .NFAULT(4), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .din(din), .dout(dout), .busy(busy), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
        .cfg_en(cfg_en), .cfg_type(cfg_type), .cfg_vaddr(cfg_vaddr), .cfg_vbit(cfg_vbit),
        .cfg_aaddr(cfg_aaddr), .cfg_abit(cfg_abit), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        write = 1'b1; address = a; din = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        read = 1'b1; address = a;
        exp_q.push_back(exp);
        @(negedge clk);
        read = 1'b0;
        check(tag, dout, exp_q.pop_front());
    endtask

    task automatic do_cfg(input logic [1:0] idx, input logic [2:0] t, input logic [2:0] va,
                          input logic [2:0] vb, input logic [2:0] aa, input logic [2:0] ab);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_en = 1'b1; cfg_idx = idx; cfg_type = t;
        cfg_vaddr = va; cfg_vbit = vb; cfg_aaddr = aa; cfg_abit = ab;
        @(negedge clk);
        cfg_wr = 1'b0; cfg_en = 1'b0;
    endtask

    // Expects the bench to be sitting on the negedge right after rst deasserted.
    task automatic check_clear(input string tag, input bit poke);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_busy_%0d", tag, i), busy, 1);
            write = (poke && i == 6);
            address = 3'd0;
            din = 8'h77;
            @(negedge clk);
        end
        write = 1'b0;
        check({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        // 1: reset and self-clear
        @(negedge clk);
        rst = 1'b0;
        check("rst_dout", dout, 8'h00);
        check("rst_hit", hit_cnt, 0);
        check_clear("init", 1'b0);
        for (int a = 0; a < 8; a++) do_read(3'(a), 8'h00, $sformatf("clear_rd_%0d", a));
        check("init_hit", hit_cnt, 0);

        // 2: SA0 at addr 4 bit 2
        do_cfg(2'd0, 3'd0, 3'd4, 3'd2, 3'd0, 3'd0);
        do_write(3'd4, 8'hFF);
        check("sa0_wr_hit", hit_cnt, 1);
        do_read(3'd4, 8'hFB, "sa0_rd");
        check("sa0_hit", hit_cnt, 1);

        // 3: TF_UP at addr 2 bit 0
        do_cfg(2'd1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0);
        do_write(3'd2, 8'h00);
        check("tfu_noop_hit", hit_cnt, 1);
        do_write(3'd2, 8'h01);
        do_read(3'd2, 8'h00, "tfu_rd1");
        do_write(3'd2, 8'hFF);
        do_read(3'd2, 8'hFE, "tfu_rd2");
        check("tfu_hit", hit_cnt, 3);

        // 4: CF_INV aggressor 1.7 -> victim 6.3
        do_cfg(2'd2, 3'd4, 3'd6, 3'd3, 3'd1, 3'd7);
        do_write(3'd6, 8'h00);
        do_write(3'd1, 8'h80);
        do_read(3'd6, 8'h08, "cf_rd1");
        check("cf_hit1", hit_cnt, 4);
        do_write(3'd1, 8'h80);
        do_read(3'd6, 8'h08, "cf_rd2");
        do_read(3'd1, 8'h80, "cf_aggr_rd");
        check("cf_hit2", hit_cnt, 4);

        // 5: read+write together, then reset restarted mid-clear
        @(negedge clk);
        read = 1'b1; write = 1'b1; address = 3'd3; din = 8'h5A;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check("rw_dout_hold", dout, 8'h80);
        do_read(3'd3, 8'h5A, "rw_rd");
        do_write(3'd5, 8'hAA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_dout", dout, 8'h00);
        check("rst2_hit", hit_cnt, 0);
        check_clear("reinit", 1'b1);
        do_read(3'd5, 8'h00, "reinit_rd5");
        do_read(3'd0, 8'h00, "busy_wr_ignored");
        do_write(3'd4, 8'hFF);
        do_read(3'd4, 8'hFF, "slots_cleared");
        check("reinit_hit", hit_cnt, 0);

        // 6: SA1 on bits 0-3 of addr 0, saturate the counter
        for (int i = 0; i < 4; i++) do_cfg(2'(i), 3'd1, 3'd0, 3'(i), 3'd0, 3'd0);
        @(negedge clk);
        write = 1'b1; address = 3'd0; din = 8'h00;
        repeat (254) @(negedge clk);
        check("sat_254", hit_cnt, 254);
        repeat (46) @(negedge clk);
        write = 1'b0;
        check("sat_255", hit_cnt, 255);
        do_read(3'd0, 8'h0F, "sa1_rd");
        check("sat_hold", hit_cnt, 255);

        // reserved type stores the slot disabled
        do_cfg(2'd0, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0);
        do_write(3'd7, 8'h00);
        do_read(3'd7, 8'h00, "reserved_rd");
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
